frame_sync_regfile: RTL and testbench

FRAME_SYNC_REGFILE -- requirements
Module: frame_sync_regfile

---
 rtl/frame_sync_regfile_if.sv | 27 ++
 rtl/frame_sync_regfile.sv | 152 +++++++++++++++
 tb/tb_frame_sync_regfile.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sync_regfile_if.sv
// Bundles the UART-in, vblank, register-bank and response signals of frame_sync_regfile.
// Ports: i_rx_byte/i_rx_valid (byte strobe), i_vblank, o_regs (active bank),
//   o_frame_strobe, o_dirty, o_resp_byte/o_resp_valid/i_resp_ready, o_resp_overrun.
interface frame_sync_regfile_if #(
  parameter int NUM_REGS = 4
);
  logic [7:0]            i_rx_byte;
  logic                  i_rx_valid;
  logic                  i_vblank;
  logic [8*NUM_REGS-1:0] o_regs;
  logic                  o_frame_strobe;
  logic                  o_dirty;
  logic [7:0]            o_resp_byte;
  logic                  o_resp_valid;
  logic                  i_resp_ready;
  logic                  o_resp_overrun;

  // master drives bytes/vblank and consumes responses; slave is the register file
  modport master (
    output i_rx_byte, i_rx_valid, i_vblank, i_resp_ready,
    input  o_regs, o_frame_strobe, o_dirty, o_resp_byte, o_resp_valid, o_resp_overrun
  );
  modport slave (
    input  i_rx_byte, i_rx_valid, i_vblank, i_resp_ready,
    output o_regs, o_frame_strobe, o_dirty, o_resp_byte, o_resp_valid, o_resp_overrun
  );
endinterface

// File: rtl/frame_sync_regfile.sv
// Double-buffered control registers loaded from UART bytes, committed to the active bank on vblank rise.
// Latency: shadow write 1 clk after final byte; active/o_frame_strobe 1 clk after the vblank edge cycle.
// Backpressure: single-entry response buffer; a response arriving while it is full and not accepted is
//   dropped and sets the sticky o_resp_overrun. Ports: i_clk, i_rst (async high), bus (slave modport).
module frame_sync_regfile #(
  parameter int NUM_REGS       = 4,
  parameter int MODE           = 1,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  frame_sync_regfile_if.slave  bus
);
  localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] SYNC_BYTE = 8'h5A;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
  localparam logic [8:0] NREG9     = 9'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, GOT_SYNC, GOT_ADDR} state_t;

  state_t        state, state_nxt;
  logic [7:0]    addr, addr_nxt;
  logic [TW-1:0] timer, timer_nxt;

  logic [7:0] shadow [NUM_REGS];
  logic [7:0] active [NUM_REGS];

  logic       r_vblank, armed, dirty, strobe;
  logic       resp_vld, overrun;
  logic [7:0] resp_dat;

  logic       rx_ok, vb_edge, resp_acc;
  logic       wr_en, q_vld;
  logic [7:0] wr_addr, wr_dat, q_dat;

  // armed is low for the first clock after reset release so a byte there is dropped
  assign rx_ok    = bus.i_rx_valid & armed;
  assign vb_edge  = bus.i_vblank & ~r_vblank;
  assign resp_acc = resp_vld & bus.i_resp_ready;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    timer_nxt = timer;
    wr_en     = 1'b0;
    wr_addr   = addr;
    wr_dat    = bus.i_rx_byte;
    q_vld     = 1'b0;
    q_dat     = NAK_BYTE;
    if (MODE == 0) begin
      state_nxt = IDLE;
      timer_nxt = '0;
      if (rx_ok) begin
        wr_en   = 1'b1;
        wr_addr = 8'h00;
      end
    end else begin
      case (state)
        IDLE: begin
          timer_nxt = '0;
          if (rx_ok && bus.i_rx_byte == SYNC_BYTE) state_nxt = GOT_SYNC;
        end
        GOT_SYNC, GOT_ADDR: begin
          if (rx_ok) begin
            timer_nxt = '0;
            if (state == GOT_SYNC) begin
              addr_nxt  = bus.i_rx_byte;
              state_nxt = GOT_ADDR;
            end else begin
              state_nxt = IDLE;
              q_vld     = 1'b1;
              // full 8-bit compare so e.g. 0x84 never aliases onto a low register
              if ({1'b0, addr} < NREG9) begin
                wr_en = 1'b1;
                q_dat = ACK_BYTE;
              end
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            // this idle clock brings the count to TIMEOUT_CYCLES
            state_nxt = IDLE;
            timer_nxt = '0;
            q_vld     = 1'b1;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      addr  <= 8'h00;
      timer <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      timer <= timer_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow[k] <= 8'h00;
        active[k] <= 8'h00;
      end
      r_vblank <= 1'b0;
      armed    <= 1'b0;
      dirty    <= 1'b0;
      strobe   <= 1'b0;
      resp_vld <= 1'b0;
      resp_dat <= 8'h00;
      overrun  <= 1'b0;
    end else begin
      armed    <= 1'b1;
      r_vblank <= bus.i_vblank;
      strobe   <= vb_edge;
      // active takes the pre-edge shadow; a same-cycle write lands in shadow only
      if (vb_edge) begin
        for (int k = 0; k < NUM_REGS; k++) active[k] <= shadow[k];
      end
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_en && wr_addr == 8'(k)) shadow[k] <= wr_dat;
      end
      if (wr_en)        dirty <= 1'b1;
      else if (vb_edge) dirty <= 1'b0;
      if (q_vld) begin
        if (!resp_vld || resp_acc) begin
          resp_vld <= 1'b1;
          resp_dat <= q_dat;
        end else begin
          overrun <= 1'b1;
        end
      end else if (resp_acc) begin
        resp_vld <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign bus.o_regs[8*g +: 8] = active[g];
  end
  assign bus.o_frame_strobe = strobe;
  assign bus.o_dirty        = dirty;
  assign bus.o_resp_byte    = resp_dat;
  assign bus.o_resp_valid   = resp_vld;
  assign bus.o_resp_overrun = overrun;
endmodule

// File: tb/tb_frame_sync_regfile.sv
// Bench for frame_sync_regfile: PACKET instance checked every cycle against a byte-stream model,
// plus directed literal expectations; a DIRECT instance covers the single-register mode.
// Ports exercised: all interface signals of both instances, shared clk/rst.
module tb_frame_sync_regfile;
  localparam int T = 40;

  logic clk;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  logic done    = 1'b0;

  frame_sync_regfile_if #(.NUM_REGS(4)) bp ();
  frame_sync_regfile_if #(.NUM_REGS(2)) bd ();

  frame_sync_regfile #(.NUM_REGS(4), .MODE(1), .TIMEOUT_CYCLES(T)) u_pkt (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bp)
  );
  frame_sync_regfile #(.NUM_REGS(2), .MODE(0), .TIMEOUT_CYCLES(T)) u_dir (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model of the PACKET instance ----------------
  logic [7:0] m_shadow [4];
  logic [7:0] m_active [4];
  logic       m_dirty, m_strobe, m_rvld, m_ovr, m_vb_prev, m_armed;
  logic [7:0] m_rbyte;
  logic [7:0] m_pkt [$];   // bytes of the command collected so far (sync, addr)
  int         m_idle;      // clocks without a byte since the last byte

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_shadow[k] = 8'h00;
      m_active[k] = 8'h00;
    end
    m_dirty = 0; m_strobe = 0; m_rvld = 0; m_ovr = 0; m_vb_prev = 0; m_armed = 0;
    m_rbyte = 8'h00;
    m_idle  = 0;
    m_pkt.delete();
  endtask

  task automatic model_step();
    logic       rx, edge_now, q, wr, acc;
    logic [7:0] b, a, qb;
    rx       = bp.i_rx_valid && m_armed;
    b        = bp.i_rx_byte;
    edge_now = bp.i_vblank && !m_vb_prev;
    q = 0; wr = 0; qb = 8'h00;
    if (edge_now) for (int k = 0; k < 4; k++) m_active[k] = m_shadow[k];
    if (rx) begin
      m_idle = 0;
      if (m_pkt.size() == 0) begin
        if (b == 8'h5A) m_pkt.push_back(b);
      end else if (m_pkt.size() == 1) begin
        m_pkt.push_back(b);
      end else begin
        a = m_pkt[1];
        q = 1;
        if (int'(a) < 4) begin
          m_shadow[a[1:0]] = b;
          wr = 1;
          qb = 8'h06;
        end else begin
          qb = 8'h15;
        end
        m_pkt.delete();
      end
    end else if (m_pkt.size() != 0) begin
      m_idle++;
      if (m_idle == T) begin
        m_pkt.delete();
        m_idle = 0;
        q = 1;
        qb = 8'h15;
      end
    end
    acc = m_rvld && bp.i_resp_ready;
    if (q) begin
      if (!m_rvld || acc) begin
        m_rbyte = qb;
        m_rvld  = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (acc) begin
      m_rvld = 0;
    end
    if (wr) m_dirty = 1;
    else if (edge_now) m_dirty = 0;
    m_strobe  = edge_now;
    m_vb_prev = bp.i_vblank;
    m_armed   = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // per-cycle comparison of the PACKET instance against the model
  initial begin
    @(negedge clk);
    while (!done) begin
      #1;
      chk("cmp_regs", bp.o_regs, {m_active[3], m_active[2], m_active[1], m_active[0]});
      chk("cmp_strobe", 32'(bp.o_frame_strobe), 32'(m_strobe));
      chk("cmp_dirty", 32'(bp.o_dirty), 32'(m_dirty));
      chk("cmp_rvld", 32'(bp.o_resp_valid), 32'(m_rvld));
      chk("cmp_rbyte", 32'(bp.o_resp_byte), 32'(m_rbyte));
      chk("cmp_ovr", 32'(bp.o_resp_overrun), 32'(m_ovr));
      @(negedge clk);
    end
  end

  // ---------------- stimulus helpers (called at a negedge, return at a negedge) ----------------
  task automatic ps(input logic [7:0] b);
    bp.i_rx_byte  = b;
    bp.i_rx_valid = 1'b1;
    @(negedge clk);
    bp.i_rx_valid = 1'b0;
  endtask

  task automatic pkt3(input logic [7:0] s, input logic [7:0] a, input logic [7:0] d);
    ps(s); ps(a); ps(d);
  endtask

  task automatic pvpulse();
    bp.i_vblank = 1'b1;
    @(negedge clk);
    bp.i_vblank = 1'b0;
  endtask

  task automatic ds(input logic [7:0] b);
    bd.i_rx_byte  = b;
    bd.i_rx_valid = 1'b1;
    @(negedge clk);
    bd.i_rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bp.i_rx_byte = 8'h00; bp.i_rx_valid = 1'b0; bp.i_vblank = 1'b0; bp.i_resp_ready = 1'b1;
    bd.i_rx_byte = 8'h00; bd.i_rx_valid = 1'b0; bd.i_vblank = 1'b0; bd.i_resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_regs", bp.o_regs, 32'h0);
    chk("rst_dirty", 32'(bp.o_dirty), 0);
    chk("rst_rvld", 32'(bp.o_resp_valid), 0);
    chk("rst_ovr", 32'(bp.o_resp_overrun), 0);

    // byte during reset-release cycle is dropped, so 07,99 are ignored in IDLE
    rst = 1'b0;
    ps(8'h5A); ps(8'h07); ps(8'h99);
    chk("release_no_resp", 32'(bp.o_resp_valid), 0);

    // write reg2=C3, commit on vblank
    pkt3(8'h5A, 8'h02, 8'hC3);
    chk("a_rvld", 32'(bp.o_resp_valid), 1);
    chk("a_rbyte", 32'(bp.o_resp_byte), 32'h06);
    chk("a_dirty", 32'(bp.o_dirty), 1);
    chk("a_regs_pre", bp.o_regs, 32'h0);
    pvpulse();
    chk("a_strobe", 32'(bp.o_frame_strobe), 1);
    chk("a_regs_post", bp.o_regs, 32'h00C30000);
    chk("a_dirty_clr", 32'(bp.o_dirty), 0);
    @(negedge clk);
    chk("a_strobe_1cyc", 32'(bp.o_frame_strobe), 0);

    // out-of-range address
    pkt3(8'h5A, 8'h07, 8'h11);
    chk("b_rbyte", 32'(bp.o_resp_byte), 32'h15);
    chk("b_rvld", 32'(bp.o_resp_valid), 1);
    chk("b_dirty", 32'(bp.o_dirty), 0);
    pvpulse();
    chk("b_regs", bp.o_regs, 32'h00C30000);

    // timeout: T idle clocks abandon the command
    ps(8'h5A); ps(8'h01);
    repeat (T - 1) @(negedge clk);
    chk("c_no_to_yet", 32'(bp.o_resp_valid), 0);
    @(negedge clk);
    chk("c_to_rvld", 32'(bp.o_resp_valid), 1);
    chk("c_to_rbyte", 32'(bp.o_resp_byte), 32'h15);
    ps(8'h22);
    chk("c_22_ignored", 32'(bp.o_resp_valid), 0);
    chk("c_dirty", 32'(bp.o_dirty), 0);
    // one clock short of the timeout still completes
    ps(8'h5A); ps(8'h01);
    repeat (T - 1) @(negedge clk);
    ps(8'h22);
    chk("c_edge_rbyte", 32'(bp.o_resp_byte), 32'h06);
    chk("c_edge_dirty", 32'(bp.o_dirty), 1);
    pvpulse();
    chk("c_edge_regs", bp.o_regs, 32'h00C32200);

    // no consumer: second response dropped, both writes land
    bp.i_resp_ready = 1'b0;
    pkt3(8'h5A, 8'h00, 8'hAA);
    pkt3(8'h5A, 8'h03, 8'hBB);
    chk("d_rvld", 32'(bp.o_resp_valid), 1);
    chk("d_rbyte", 32'(bp.o_resp_byte), 32'h06);
    chk("d_ovr", 32'(bp.o_resp_overrun), 1);
    bp.i_resp_ready = 1'b1;
    @(negedge clk);
    chk("d_drained", 32'(bp.o_resp_valid), 0);
    pvpulse();
    chk("d_regs", bp.o_regs, 32'hBBC322AA);

    // final byte coincides with the vblank edge
    ps(8'h5A); ps(8'h00);
    bp.i_rx_byte = 8'h44; bp.i_rx_valid = 1'b1; bp.i_vblank = 1'b1;
    @(negedge clk);
    bp.i_rx_valid = 1'b0; bp.i_vblank = 1'b0;
    chk("e_strobe", 32'(bp.o_frame_strobe), 1);
    chk("e_regs_old", bp.o_regs, 32'hBBC322AA);
    chk("e_dirty", 32'(bp.o_dirty), 1);
    @(negedge clk);
    pvpulse();
    chk("e_regs_new", bp.o_regs, 32'hBBC32244);
    chk("e_dirty_clr", 32'(bp.o_dirty), 0);

    // asynchronous reset mid-packet
    ps(8'h5A); ps(8'h02);
    #2 rst = 1'b1;
    #1;
    chk("f_async_regs", bp.o_regs, 32'h0);
    chk("f_async_ovr", 32'(bp.o_resp_overrun), 0);
    chk("f_async_rbyte", 32'(bp.o_resp_byte), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ps(8'h66);
    chk("f_no_resp", 32'(bp.o_resp_valid), 0);
    pvpulse();
    chk("f_regs", bp.o_regs, 32'h0);

    // accept and load in the same cycle: no overrun
    bp.i_resp_ready = 1'b0;
    pkt3(8'h5A, 8'h01, 8'h77);
    chk("g_rbyte1", 32'(bp.o_resp_byte), 32'h06);
    ps(8'h5A); ps(8'h09);
    bp.i_resp_ready = 1'b1;
    ps(8'h88);
    chk("g_rvld", 32'(bp.o_resp_valid), 1);
    chk("g_rbyte2", 32'(bp.o_resp_byte), 32'h15);
    chk("g_ovr", 32'(bp.o_resp_overrun), 0);
    @(negedge clk);
    chk("g_drained", 32'(bp.o_resp_valid), 0);
    pvpulse();
    chk("g_regs", bp.o_regs, 32'h00007700);

    // DIRECT instance
    ds(8'h12); ds(8'h34);
    chk("h_no_resp", 32'(bd.o_resp_valid), 0);
    chk("h_dirty", 32'(bd.o_dirty), 1);
    chk("h_regs_pre", 32'(bd.o_regs), 0);
    bd.i_vblank = 1'b1; bd.i_rx_byte = 8'h56; bd.i_rx_valid = 1'b1;
    @(negedge clk);
    bd.i_vblank = 1'b0; bd.i_rx_valid = 1'b0;
    chk("h_strobe", 32'(bd.o_frame_strobe), 1);
    chk("h_regs_post", 32'(bd.o_regs), 32'h0034);
    chk("h_dirty_kept", 32'(bd.o_dirty), 1);
    chk("h_no_resp2", 32'(bd.o_resp_valid), 0);
    #2 rst = 1'b1;
    #1;
    chk("h_async_regs", 32'(bd.o_regs), 0);
    chk("h_async_strobe", 32'(bd.o_frame_strobe), 0);
    chk("h_async_dirty", 32'(bd.o_dirty), 0);
    chk("h_async_rvld", 32'(bd.o_resp_valid), 0);
    chk("h_async_rbyte", 32'(bd.o_resp_byte), 0);
    chk("h_async_ovr", 32'(bd.o_resp_overrun), 0);

    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
